// File: rtl/risky_pkg.sv
// Shared types for the core's memory path: access sizes, responder FSM states and
// the request record captured by the data-memory responder.
package risky_pkg;

  localparam int DMEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
  } dmem_req_t;

  // Encoding 3 is the only illegal size.
  function automatic logic size_legal(input logic [1:0] size);
    return size != 2'd3;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for data memory: byte enables, replicated store word and
// sign/zero-extended load data. Purely combinational; shared with the mem stage.
module dmem_lane_align
  import risky_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half accesses ignore addr[0], which aligns them down to the halfword.
  assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    be_o    = 4'b0000;
    wword_o = wdata_i;
    rdata_o = '0;
    case (size_i)
      MEM_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      end
      MEM_W: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array with byte-lane writes, wait-state latency model
// and valid/ready response. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module data_mem_responder
  import risky_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT =
      (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_W'(WAIT_CYCLES - 1);

  dmem_state_e state_q, state_d;
  logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;
  dmem_req_t   req_q, req_d, req_in, cur_req;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        access;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic        range_err, size_err, align_err, acc_err, mem_we;
  logic [3:0]  be;
  logic [31:0] wword, rword, rdata_ext;

  always_comb begin
    req_in.we          = req_we_i;
    req_in.addr        = req_addr_i;
    req_in.wdata       = req_wdata_i;
    req_in.size        = req_size_i;
    req_in.is_unsigned = req_unsigned_i;
  end

  // With no wait states the access edge is the acceptance edge, so use the live request.
  assign cur_req = (state_q == IDLE) ? req_in : req_q;

  assign idx       = cur_req.addr[AW+1:2];
  assign range_err = |(cur_req.addr >> (AW + 2));
  assign size_err  = !size_legal(cur_req.size);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign align_err = ((cur_req.size == MEM_H) && cur_req.addr[0]) ||
                     ((cur_req.size == MEM_W) && (cur_req.addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign acc_err = range_err | size_err | align_err;
  assign rword   = mem[idx];
  assign mem_we  = access & cur_req.we & ~acc_err;

  dmem_lane_align u_lane_align (
    .size_i     (cur_req.size),
    .addr_lo_i  (cur_req.addr[1:0]),
    .unsigned_i (cur_req.is_unsigned),
    .wdata_i    (cur_req.wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wword_o    (wword),
    .rdata_o    (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset; contents survive rst_n and it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_d = req_in;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response data is latched only on the access edge and held through backpressure.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || cur_req.we) ? 32'h0 : rdata_ext;
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_data_mem_responder;
  import risky_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void exp_push(input string tag, input logic [31:0] d, input logic e);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    x.tag   = tag;
    sb.push_back(x);
  endfunction

  // Monitor: compare on each response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with no expected entry",
                 rsp_rdata_o, rsp_err_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_rdata"}, rsp_rdata_o, e.rdata);
        check({e.tag, "_err"}, {31'b0, rsp_err_o}, {31'b0, e.err});
      end
    end
  end

  // Present a request and return just after its acceptance edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns);
    @(negedge clk);
    req_we_i       = we;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_valid_i    = 1'b1;
    for (int i = 0; i < 50 && !req_ready_o; i++) @(negedge clk);
    check("accept_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_d, input logic exp_e);
    exp_push(tag, exp_d, exp_e);
    send(we, addr, wdata, size, uns);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_size_i = 2'd0; req_unsigned_i = 1'b0; rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'h0);
    check("rst_err", {31'b0, rsp_err_o}, 32'd0);
    rst_n = 1'b1;

    txn("st_w_0",   1'b1, 32'h0,  32'h0123_4567, MEM_W, 1'b0, 32'h0, 1'b0);
    txn("st_w_10",  1'b1, 32'h10, 32'hDEAD_BEEF, MEM_W, 1'b0, 32'h0, 1'b0);

    // Load with latency measurement: counter starts at WAITC-1, RESP entered once it is zero.
    exp_push("ld_w_10", 32'hDEAD_BEEF, 1'b0);
    send(1'b0, 32'h10, 32'h0, MEM_W, 1'b0);
    cyc = 0;
    @(negedge clk);
    while (!rsp_valid_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("load_latency", 32'(cyc), 32'(WAITC));
    wait_done();

    txn("st_b_13",   1'b1, 32'h13, 32'h0000_0080, MEM_B, 1'b0, 32'h0, 1'b0);
    txn("ld_bs_13",  1'b0, 32'h13, 32'h0, MEM_B, 1'b0, 32'hFFFF_FF80, 1'b0);
    txn("ld_bu_13",  1'b0, 32'h13, 32'h0, MEM_B, 1'b1, 32'h0000_0080, 1'b0);
    txn("ld_w_10b",  1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 32'h80AD_BEEF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("ld_h_11",   1'b0, 32'h11, 32'h0, MEM_H, 1'b0, 32'h0, 1'b1);
`else
    txn("ld_h_11",   1'b0, 32'h11, 32'h0, MEM_H, 1'b0, 32'hFFFF_BEEF, 1'b0);
`endif
    txn("ld_hu_12",  1'b0, 32'h12, 32'h0, MEM_H, 1'b1, 32'h0000_80AD, 1'b0);
    txn("st_oob",    1'b1, DEPTH * 4, 32'hFFFF_FFFF, MEM_W, 1'b0, 32'h0, 1'b1);
    txn("ld_w_0",    1'b0, 32'h0, 32'h0, MEM_W, 1'b0, 32'h0123_4567, 1'b0);
    txn("ld_size3",  1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1);
    txn("st_w_14",   1'b1, 32'h14, 32'h0, MEM_W, 1'b0, 32'h0, 1'b0);
    txn("st_h_16",   1'b1, 32'h16, 32'h0000_CAFE, MEM_H, 1'b0, 32'h0, 1'b0);
    txn("ld_w_14",   1'b0, 32'h14, 32'h0, MEM_W, 1'b0, 32'hCAFE_0000, 1'b0);

    // Backpressure with a second request waiting behind the held response.
    rsp_ready_i = 1'b0;
    exp_push("bp_first", 32'h80AD_BEEF, 1'b0);
    send(1'b0, 32'h10, 32'h0, MEM_W, 1'b0);
    for (int i = 0; i < 40 && !rsp_valid_o; i++) @(negedge clk);
    check("bp_valid_seen", {31'b0, rsp_valid_o}, 32'd1);
    req_we_i = 1'b0; req_addr_i = 32'h10; req_size_i = MEM_B; req_unsigned_i = 1'b1;
    req_valid_i = 1'b1;
    exp_push("bp_second", 32'h0000_00EF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'b0, rsp_valid_o}, 32'd1);
      check("bp_hold_rdata", rsp_rdata_o, 32'h80AD_BEEF);
      check("bp_hold_req_ready", {31'b0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    send(1'b0, 32'h10, 32'h0, MEM_B, 1'b1);
    wait_done();

    // Reset while a store sits in WAIT: the write must not happen.
    send(1'b1, 32'h10, 32'h1234_5678, MEM_W, 1'b0);
    rst_n = 1'b0;
    #2;
    check("wrst_req_ready", {31'b0, req_ready_o}, 32'd1);
    check("wrst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("wrst_rdata", rsp_rdata_o, 32'h0);
    check("wrst_err", {31'b0, rsp_err_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn("ld_after_rst", 1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 32'h80AD_BEEF, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
